// File: rtl/clock_divider_nch_if.sv
// Control/status bundle for clock_divider_nch.
// Defining CLKDIV_PHASE_SYNC_EN adds the sync pulse input.
interface clock_divider_nch_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16
);
  // load[i] is a single-cycle request with no ready: it is always accepted.
  // pend[i] stays high until the captured divisor takes effect.
  // Every other signal is a level.
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH*DIV_W-1:0] div_val;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       pend;
  logic [2*NUM_CH-1:0]     state_dbg;
`ifdef CLKDIV_PHASE_SYNC_EN
  logic                    sync;

  modport master (
    output ch_en, div_val, load, sync,
    input  clk_out, tick, pend, state_dbg
  );
  modport slave (
    input  ch_en, div_val, load, sync,
    output clk_out, tick, pend, state_dbg
  );
`else
  modport master (
    output ch_en, div_val, load,
    input  clk_out, tick, pend, state_dbg
  );
  modport slave (
    input  ch_en, div_val, load,
    output clk_out, tick, pend, state_dbg
  );
`endif
endinterface

// File: rtl/clock_divider_nch.sv
// Multi-channel divide-by-2*D clock generator with shadowed divisors and
// boundary-only updates. Optional phase realignment: CLKDIV_PHASE_SYNC_EN.
module clock_divider_nch #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16
) (
  input  logic               clk_in,
  input  logic               reset_n,
  clock_divider_nch_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [DIV_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic [DIV_W-1:0] div_shd_q, div_shd_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             clk_out_q, clk_out_d;
    logic             last_cnt;
    logic             apply;
    logic [DIV_W-1:0] div_next;

    always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      div_act_d = div_act_q;
      div_shd_d = div_shd_q;
      pend_d    = pend_q;
      tick_d    = 1'b0;
      apply     = 1'b0;
      // div_act_q is never 0 outside IDLE, so the compare cannot underflow.
      last_cnt  = (count_q == (div_act_q - DIV_W'(1)));
      // Divisor that governs the next period once a boundary is taken.
      div_next  = pend_q ? div_shd_q : div_act_q;

      case (state_q)
        ST_IDLE: begin
          apply   = pend_q;
          count_d = '0;
          if (bus.ch_en[g] && (div_next != '0)) begin
            state_d = ST_HIGH;
            tick_d  = 1'b1;
          end
        end
        ST_HIGH: begin
          if (last_cnt) begin
            state_d = ST_LOW;
            count_d = '0;
          end else begin
            count_d = count_q + DIV_W'(1);
          end
        end
        ST_LOW: begin
          if (last_cnt) begin
            apply   = pend_q;
            count_d = '0;
            if (bus.ch_en[g] && (div_next != '0)) begin
              state_d = ST_HIGH;
              tick_d  = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            count_d = count_q + DIV_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase

`ifdef CLKDIV_PHASE_SYNC_EN
      // Sync overrides whatever the running FSM chose, including a boundary.
      if (bus.sync && (state_q != ST_IDLE)) begin
        apply   = pend_q;
        count_d = '0;
        if (div_next != '0) begin
          state_d = ST_HIGH;
          tick_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          tick_d  = 1'b0;
        end
      end
`endif

      // Apply before capture so a coincident load is kept for the next boundary.
      if (apply) begin
        div_act_d = div_shd_q;
        pend_d    = 1'b0;
      end
      if (bus.load[g]) begin
        div_shd_d = bus.div_val[g*DIV_W +: DIV_W];
        pend_d    = 1'b1;
      end

      clk_out_d = (state_d == ST_HIGH);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
        state_q   <= ST_IDLE;
        count_q   <= '0;
        div_act_q <= DIV_W'(1);
        div_shd_q <= DIV_W'(1);
        pend_q    <= 1'b0;
        tick_q    <= 1'b0;
        clk_out_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        count_q   <= count_d;
        div_act_q <= div_act_d;
        div_shd_q <= div_shd_d;
        pend_q    <= pend_d;
        tick_q    <= tick_d;
        clk_out_q <= clk_out_d;
      end
    end

    assign bus.clk_out[g]          = clk_out_q;
    assign bus.tick[g]             = tick_q;
    assign bus.pend[g]             = pend_q;
    assign bus.state_dbg[2*g +: 2] = state_q;
  end

endmodule

// File: doc/clock_divider_nch.md
Name: clock_divider_nch

Overview:
- Multi-channel programmable clock divider for the LED driver timing chain. Successor to the fixed power-of-2 divider.
- Each of NUM_CH channels divides clk_in by a runtime integer 2*D, where D comes from a per-channel divisor register.
- Each channel produces a 50%-duty clk_out plus a single-cycle tick strobe, with glitch-free divisor updates and glitch-free enable/disable.
- Feeds PWM/scan blocks that need several related slow rates.

Parameters:
- NUM_CH, 4, number of independent channels (>=1).
- DIV_W, 16, width of each divisor D; legal D range 0..2^DIV_W-1.

Ports:
- clk_in  input  1  sole clock, all logic on posedge.
- reset_n  input  1  asynchronous active-low reset.
- ch_en  input  NUM_CH  per-channel run enable, level.
- div_val  input  NUM_CH*DIV_W  per-channel divisor; channel i at bits [i*DIV_W +: DIV_W].
- load  input  NUM_CH  one-cycle request to capture div_val[i] into the channel's shadow register.
- clk_out  output  NUM_CH  divided clocks, registered.
- tick  output  NUM_CH  one-cycle strobe, high during the first clk_in cycle of each clk_out high phase.
- pend  output  NUM_CH  high while a captured divisor waits to be applied.

Behaviour:
- Reset (reset_n low, async): clk_out=0, tick=0, pend=0, count=0, active D=1, shadow=1, all channels IDLE.
- Per-channel FSM:
  - IDLE: clk_out=0, count=0.
  - IDLE->HIGH when ch_en=1 and active D!=0. clk_out=1 and tick=1 starting the cycle after ch_en is sampled high (latency 1).
  - HIGH: clk_out=1 for exactly D clk_in cycles. count runs 0..D-1.
  - At count==D-1: go to LOW, count=0.
  - LOW: clk_out=0 for exactly D cycles.
  - At count==D-1: go to HIGH with tick=1, or to IDLE if ch_en=0.
- Resulting period 2*D clk_in cycles; duty exactly 50%.
- D=1 gives clk_in/2 with tick every 2 cycles.
- D=0: channel is held in IDLE regardless of ch_en; clk_out stays 0.
- Divisor update:
  - load[i]=1 captures div_val slice into the shadow register and sets pend[i].
  - Shadow is copied to active D, and pend[i] cleared, only at a period boundary: the LOW->HIGH/IDLE transition, or immediately next cycle if the channel is IDLE.
  - The current period always completes with the old D; no runt pulses.
  - A second load while pend=1 overwrites the shadow (last wins). pend stays 1.
  - load coincident with a boundary: the boundary applies the prior shadow. The new value is captured and pend=1 for the next boundary.
- Disable: ch_en dropping mid-period does not truncate. The channel finishes the current HIGH and LOW halves, then enters IDLE. ch_en re-asserted before the boundary means continuous running, with no gap.
- Counter compare is equality on DIV_W bits. count never exceeds D-1, so there is no wrap hazard.
- Channels are fully independent; no shared state.
- reset_n asserted mid-operation: all outputs drop to 0 immediately (async). Active D and shadow return to 1.

Optional Feature:
- Macro CLKDIV_PHASE_SYNC_EN.
- When defined:
  - Adds input sync (1 bit).
  - A one-cycle sync pulse forces every running channel to restart its period. Next cycle: clk_out=1, tick=1, count=0, any pending shadow applied.
  - IDLE channels are unaffected.
  - This phase-aligns all channels.
  - sync takes priority over a coincident natural boundary.
- When undefined: no sync port; channels free-run from their own enable times.

Test Plan:
- Reset, ch_en[0]=1, D=1 → clk_out[0] toggles every cycle, tick[0] every 2 cycles, first tick 1 cycle after enable.
- load[1] D=5, ch_en[1]=1 → clk_out[1] 5 high/5 low, period 10, tick[1] spacing exactly 10.
- Ch2 running D=4; load D=2 at cycle 3 of HIGH → pend=1, remaining 1 HIGH + 4 LOW cycles at D=4, then period 4, pend=0 at the boundary.
- Ch3 D=3; drop ch_en at cycle 1 of HIGH → HIGH 3 cycles, LOW 3 cycles, then IDLE. No further tick. Re-enable → tick 1 cycle later.
- load D=0 on running ch0 → finishes the period, then IDLE with clk_out=0 despite ch_en=1.
- CLKDIV_PHASE_SYNC_EN, ch0 D=2 and ch1 D=3 running out of phase; pulse sync → both tick next cycle, rising edges aligned every 12 cycles. Assert reset_n low mid-run → all outputs 0 immediately.
